// File: rtl/scoreboard_reader_if.sv
// Record stream from scoreboard_reader to a consumer.
// master presents {user_id, score} records; slave returns ready.
interface scoreboard_reader_if;
    logic        entry_valid;
    logic        entry_ready;
    logic [31:0] entry_data;
    logic [7:0]  entry_index;

    modport master (
        output entry_valid,
        output entry_data,
        output entry_index,
        input  entry_ready
    );

    modport slave (
        input  entry_valid,
        input  entry_data,
        input  entry_index,
        output entry_ready
    );
endinterface

// File: rtl/scoreboard_reader.sv
// Scans scoreboard RAM and streams {user_id, score} records, tracking the best score.
// Optional: SCOREBOARD_SKIP_EMPTY_EN skips records whose user_id is zero.
module scoreboard_reader #(
    parameter int          ENTRY_COUNT = 16,
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          RD_LAT      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [15:0]                ram_address,
    input  logic [15:0]                ram_data,
    scoreboard_reader_if.master        ent,
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                best_data
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ID   = 3'd1;
    localparam logic [2:0] RD_SC   = 3'd2;
    localparam logic [2:0] PRESENT = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]  state;
    logic [2:0]  wait_cnt;
    logic [15:0] user_id;
    logic [7:0]  index;
    logic [31:0] best;
    logic        have_best;
    logic        valid_q;
    logic [31:0] data_q;

    logic        last;
    logic        fire;
    logic        wait_done;
    logic        take;
    logic        skip;
    logic [31:0] best_nxt;

    assign ent.entry_valid = valid_q;
    assign ent.entry_data  = data_q;
    assign ent.entry_index = index;

    assign last      = (index == 8'(ENTRY_COUNT - 1));
    assign fire      = (state == PRESENT) && valid_q && ent.entry_ready;
    assign wait_done = (wait_cnt == 3'(RD_LAT));

`ifdef SCOREBOARD_SKIP_EMPTY_EN
    assign skip = (user_id == 16'h0000);
`else
    assign skip = 1'b0;
`endif

    // The first counted record always seeds best; later ones replace it only when strictly higher.
    always_comb begin
        take     = fire && (!have_best || (data_q[15:0] > best[15:0]));
        best_nxt = take ? data_q : best;
    end

    // Scan FSM: wait RD_LAT clocks per word, sample on the following edge, then present.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wait_cnt    <= 3'd0;
            user_id     <= 16'h0000;
            index       <= 8'd0;
            best        <= 32'h0;
            have_best   <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= 32'h0;
            ram_address <= BASE_ADDR;
            busy        <= 1'b0;
            done        <= 1'b0;
            best_data   <= 32'h0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ram_address <= BASE_ADDR;
                        index       <= 8'd0;
                        best        <= 32'h0;
                        have_best   <= 1'b0;
                        wait_cnt    <= 3'd0;
                        busy        <= 1'b1;
                        state       <= RD_ID;
                    end
                end
                RD_ID: begin
                    if (wait_done) begin
                        user_id     <= ram_data;
                        ram_address <= ram_address + 16'd1;
                        wait_cnt    <= 3'd0;
                        state       <= RD_SC;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                RD_SC: begin
                    if (wait_done) begin
                        wait_cnt <= 3'd0;
                        if (skip) begin
                            if (last) begin
                                best_data <= best;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                state     <= DONE;
                            end else begin
                                index       <= index + 8'd1;
                                ram_address <= ram_address + 16'd1;
                                state       <= RD_ID;
                            end
                        end else begin
                            data_q  <= {user_id, ram_data};
                            valid_q <= 1'b1;
                            state   <= PRESENT;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                PRESENT: begin
                    if (fire) begin
                        valid_q <= 1'b0;
                        best    <= best_nxt;
                        if (take) begin
                            have_best <= 1'b1;
                        end
                        if (last) begin
                            best_data <= best_nxt;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            index       <= index + 8'd1;
                            ram_address <= ram_address + 16'd1;
                            state       <= RD_ID;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scoreboard_reader.sv
// Directed bench for scoreboard_reader: three instances at RD_LAT 2, 1 and 3.
// Record 2 skip expectations follow SCOREBOARD_SKIP_EMPTY_EN.
module tb_scoreboard_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, start1, start3;
    logic [15:0] addr, addr1, addr3;
    logic [15:0] rdata, rdata1, rdata3;
    logic        busy, done, busy1, done1, busy3, done3;
    logic [31:0] best, best1, best3;
    logic [15:0] mem [0:15];

    int checks = 0;
    int failures = 0;

    scoreboard_reader_if mif ();
    scoreboard_reader_if if1 ();
    scoreboard_reader_if if3 ();

    assign if1.entry_ready = 1'b1;
    assign if3.entry_ready = 1'b1;

    scoreboard_reader #(.ENTRY_COUNT(4), .BASE_ADDR(16'h0100), .RD_LAT(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .ram_address(addr),
        .ram_data(rdata), .ent(mif), .busy(busy), .done(done),
        .best_data(best)
    );

    scoreboard_reader #(.ENTRY_COUNT(4), .BASE_ADDR(16'h0000), .RD_LAT(1)) u_l1 (
        .clk(clk), .rst(rst), .start(start1), .ram_address(addr1),
        .ram_data(rdata1), .ent(if1), .busy(busy1), .done(done1),
        .best_data(best1)
    );

    scoreboard_reader #(.ENTRY_COUNT(4), .BASE_ADDR(16'h0000), .RD_LAT(3)) u_l3 (
        .clk(clk), .rst(rst), .start(start3), .ram_address(addr3),
        .ram_data(rdata3), .ent(if3), .busy(busy3), .done(done3),
        .best_data(best3)
    );

    // RAM models: address pipelines of depth RD_LAT.
    logic [15:0] p2 [0:1];
    logic [15:0] p1;
    logic [15:0] p3 [0:2];

    always @(posedge clk) begin
        p2[0] <= addr;
        p2[1] <= p2[0];
        p1    <= addr1;
        p3[0] <= addr3;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    always_comb begin
        rdata  = (p2[1][15:4] == 12'h010) ? mem[p2[1][3:0]] : 16'hDEAD;
        rdata1 = (p1[15:4] == 12'h000) ? mem[p1[3:0]] : 16'hDEAD;
        rdata3 = (p3[2][15:4] == 12'h000) ? mem[p3[2][3:0]] : 16'hDEAD;
    end

    // Log accepted records and done pulses of the main instance.
    logic [39:0] acc_q [$];
    int done_cnt = 0;

    always @(posedge clk) begin
        if (mif.entry_valid && mif.entry_ready)
            acc_q.push_back({mif.entry_index, mif.entry_data});
        if (done)
            done_cnt++;
    end

    task automatic check(input string tag, input logic [39:0] got,
                         input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic load_default();
        mem[0] = 16'h0011; mem[1] = 16'd5;
        mem[2] = 16'h0022; mem[3] = 16'd9;
        mem[4] = 16'h0033; mem[5] = 16'd9;
        mem[6] = 16'h0044; mem[7] = 16'd2;
        for (int i = 8; i < 16; i++) mem[i] = 16'hBEEF;
    endtask

    task automatic kick(output int lat);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 40'(busy), 40'd1);
        lat = 0;
        while (!mif.entry_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, 40'(done), 40'd1);
        check({tag, "_busy"}, 40'(busy), 40'd0);
    endtask

    task automatic check_recs(input string tag, input int base, input int n_exp);
        int k;
        k = 0;
        check({tag, "_cnt"}, 40'(acc_q.size() - base), 40'(n_exp));
        for (int r = 0; r < 4; r++) begin
`ifdef SCOREBOARD_SKIP_EMPTY_EN
            if (mem[2*r] == 16'h0000) continue;
`endif
            if (base + k < acc_q.size())
                check({tag, "_rec"}, acc_q[base+k],
                      {8'(r), mem[2*r], mem[2*r+1]});
            k++;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, b0, d0, n;
        logic [31:0] hold_d;
        logic [15:0] hold_a;
        logic stable;

        rst = 1'b0;
        start = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        mif.entry_ready = 1'b1;
        load_default();
        repeat (2) @(negedge clk);

        check("rst_addr", 40'(addr), 40'h0100);
        check("rst_valid", 40'(mif.entry_valid), 40'd0);
        check("rst_data", 40'(mif.entry_data), 40'd0);
        check("rst_index", 40'(mif.entry_index), 40'd0);
        check("rst_busy", 40'(busy), 40'd0);
        check("rst_done", 40'(done), 40'd0);
        check("rst_best", 40'(best), 40'd0);

        rst = 1'b1;
        @(negedge clk);

        // Normal scan, tie keeps index 1.
        b0 = acc_q.size();
        d0 = done_cnt;
        kick(lat);
        check("lat_rd2", 40'(lat), 40'd6);
        check("a_first_idx", 40'(mif.entry_index), 40'd0);
        check("a_best_hold", 40'(best), 40'd0);
        wait_done("a_done");
        check("a_best", 40'(best), 40'h00220009);
        @(negedge clk);
        check_recs("a", b0, 4);
        check("a_done_cnt", 40'(done_cnt - d0), 40'd1);

        // Repeated start at +1 and +5, and start during DONE.
        b0 = acc_q.size();
        d0 = done_cnt;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("d_done");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("d_done_start_ign", 40'(busy), 40'd0);
        repeat (10) @(negedge clk);
        check("d_busy_idle", 40'(busy), 40'd0);
        check_recs("d", b0, 4);
        check("d_done_cnt", 40'(done_cnt - d0), 40'd1);

        // Back-pressure on record 1.
        b0 = acc_q.size();
        d0 = done_cnt;
        mif.entry_ready = 1'b0;
        kick(lat);
        check("b_lat", 40'(lat), 40'd6);
        mif.entry_ready = 1'b1;
        @(negedge clk);
        mif.entry_ready = 1'b0;
        n = 0;
        while (!mif.entry_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b_idx", 40'(mif.entry_index), 40'd1);
        check("b_data", 40'(mif.entry_data), 40'h00220009);
        hold_d = mif.entry_data;
        hold_a = addr;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            stable &= (mif.entry_valid === 1'b1) && (mif.entry_data === hold_d)
                    && (addr === hold_a) && (mif.entry_index === 8'd1);
        end
        check("b_stable", 40'(stable), 40'd1);
        mif.entry_ready = 1'b1;
        wait_done("b_done");
        check("b_best", 40'(best), 40'h00220009);
        @(negedge clk);
        check_recs("b", b0, 4);
        check("b_done_cnt", 40'(done_cnt - d0), 40'd1);

        // Reset while record 1 is in RD_SC.
        kick(lat);
        repeat (5) @(negedge clk);
        check("c_pre_idx", 40'(mif.entry_index), 40'd1);
        check("c_pre_data", 40'(mif.entry_data), 40'h00110005);
        rst = 1'b0;
        #1;
        check("c_addr", 40'(addr), 40'h0100);
        check("c_valid", 40'(mif.entry_valid), 40'd0);
        check("c_data", 40'(mif.entry_data), 40'd0);
        check("c_index", 40'(mif.entry_index), 40'd0);
        check("c_busy", 40'(busy), 40'd0);
        check("c_done", 40'(done), 40'd0);
        check("c_best", 40'(best), 40'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        b0 = acc_q.size();
        d0 = done_cnt;
        kick(lat);
        check("c_lat", 40'(lat), 40'd6);
        wait_done("c_done2");
        check("c_best2", 40'(best), 40'h00220009);
        @(negedge clk);
        check_recs("c", b0, 4);
        check("c_done_cnt", 40'(done_cnt - d0), 40'd1);

        // Empty record 2 with a high score.
        mem[4] = 16'h0000;
        mem[5] = 16'hFFFF;
        b0 = acc_q.size();
        kick(lat);
        wait_done("e_done");
`ifdef SCOREBOARD_SKIP_EMPTY_EN
        check("e_best", 40'(best), 40'h00220009);
        @(negedge clk);
        check_recs("e", b0, 3);
`else
        check("e_best", 40'(best), 40'h0000FFFF);
        @(negedge clk);
        check_recs("e", b0, 4);
`endif

        // All scores zero: first record stays best.
        load_default();
        mem[1] = 16'd0;
        mem[3] = 16'd0;
        mem[5] = 16'd0;
        mem[7] = 16'd0;
        kick(lat);
        wait_done("g_done");
        check("g_best", 40'(best), 40'h00110000);
        @(negedge clk);

        // Latency at RD_LAT 1 and 3.
        load_default();
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 0;
        while (!if1.entry_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("lat_rd1", 40'(lat), 40'd4);
        check("l1_data", 40'(if1.entry_data), 40'h00110005);
        n = 0;
        while (!done1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("l1_done", 40'(done1), 40'd1);
        check("l1_best", 40'(best1), 40'h00220009);

        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        lat = 0;
        while (!if3.entry_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("lat_rd3", 40'(lat), 40'd8);
        check("l3_data", 40'(if3.entry_data), 40'h00110005);
        n = 0;
        while (!done3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("l3_done", 40'(done3), 40'd1);
        check("l3_best", 40'(best3), 40'h00220009);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scoreboard_reader.md
Name: scoreboard_reader

Overview:
- Read-side counterpart to the scoreboard writer: on a start pulse, scans the scoreboard RAM and streams each stored (user_id, score) record out over a valid/ready handshake.
- Also reports the highest score found during the scan.
- Sits between the scoreboard RAM read port and consumers such as the leaderboard display and serial dump logic.
- Read-only: it never writes the RAM.

Parameters:
- ENTRY_COUNT, 16, number of records scanned; 1..256.
- BASE_ADDR, 16'h0000, RAM word address of record 0.
- RD_LAT, 2, clocks from a ram_address change until ram_data holds that word; 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
- ram_address  out  16  RAM read address, registered.
- ram_data  in  16  RAM read data.
- entry_valid  out  1  entry_data and entry_index are valid.
- entry_ready  in  1  consumer accepts the record when both valid and ready are high at a clock edge.
- entry_data  out  32  {user_id[15:0], score[15:0]}.
- entry_index  out  8  record number, 0..ENTRY_COUNT-1.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last record is handled.
- best_data  out  32  {user_id, score} of the highest score in the last completed scan.

Behaviour:
- Record layout: record k has user_id at BASE_ADDR+2k and score at BASE_ADDR+2k+1, both 16-bit unsigned.
- Reset (rst low, asynchronous) forces all of the following, regardless of the current state:
  - state IDLE;
  - ram_address=BASE_ADDR;
  - entry_valid=0, entry_data=0, entry_index=0;
  - busy=0, done=0, best_data=0;
  - internal best and index registers cleared.
- States:
  - IDLE: on start=1, set ram_address=BASE_ADDR, index=0, clear internal best; go to RD_ID.
  - RD_ID: a wait counter counts RD_LAT clocks, then latches ram_data into user_id, sets ram_address+1, and goes to RD_SC.
  - RD_SC: waits RD_LAT clocks, then latches ram_data into score and goes to PRESENT.
  - PRESENT: entry_valid=1 with the data held stable. On valid&&ready:
    - update best if score > best score (strictly greater, so ties keep the earlier record);
    - if index==ENTRY_COUNT-1, go to DONE;
    - else index+1, ram_address+1, go to RD_ID.
    - entry_valid drops the cycle after acceptance.
  - DONE: copy internal best to best_data, pulse done for one cycle, return to IDLE; busy deasserts in the same cycle done is high.
- Latency: the first entry_valid appears 2*RD_LAT+2 clocks after start is sampled.
- Back-pressure: entry_ready held low stalls indefinitely in PRESENT. entry_data must not change while valid is high.
- Ignored inputs:
  - start while busy is ignored; it does not restart the scan.
  - start in the DONE cycle is ignored.
- best_data changes only in DONE; it holds its previous value throughout a scan.
- If every counted score is 0, best_data = the first counted record (score 0 is not > 0, so the initial best is never replaced). With SCOREBOARD_SKIP_EMPTY_EN defined and all records empty, best_data=0.
- entry_index wraps nowhere: ENTRY_COUNT bounds it. ram_address arithmetic is modulo 2^16.

Optional Feature:
- SCOREBOARD_SKIP_EMPTY_EN defined:
  - in RD_SC completion, a record with user_id==16'h0000 is not presented;
  - it is not counted for best;
  - the FSM advances directly (index+1, or DONE if it was the last record);
  - entry_index still reports the true record number, so gaps are visible.
- Undefined: every record is presented, including user_id 0.

Test Plan:
- Reset mid-scan: drop rst while in RD_SC -> all outputs return to reset values immediately; after release, start runs a full clean scan from record 0.
- RAM holds ENTRY_COUNT=4 records {0x0011,5},{0x0022,9},{0x0033,9},{0x0044,2}; start with entry_ready=1 -> four records in index order, done pulse, best_data=0x00220009 (tie keeps index 1).
- Back-pressure: ready low for 10 cycles while record 1 is valid -> valid stays 1, entry_data and ram_address stable; release -> scan continues normally and ends with the correct done.
- Repeated start: pulse start at cycles +1 and +5 after the first start -> exactly one scan, one done pulse.
- SCOREBOARD_SKIP_EMPTY_EN with record 2 user_id=0x0000 score=0xFFFF -> only indices 0,1,3 are presented; best_data excludes 0xFFFF. Same stimulus with the macro undefined -> index 2 is presented and best_data=0x0000FFFF.
- RD_LAT=1 vs RD_LAT=3 -> first entry_valid at 4 and 8 clocks after start respectively; data correct in both.
